cdb_arbiter: RTL and testbench

Round-robin arbiter that shares the single common data bus (CDB) among the OOO core's functional units: ALU reservation station, multiplier, load/store queue and branch unit. Each requester hands over a completed `data_bus_package_t` through a valid/ready handshake into a one-entry holding buffer. The arbiter drains one buffer per cycle onto a registered CDB output, which the ROB, RAT and physical regfile consume. A flush from a branch mismatch discards all pending results.

---
 rtl/cdb_arbiter.sv | 123 ++++++++++++
 tb/tb_cdb_arbiter.sv | 209 ++++++++++++++++++++
 2 files changed

// File: rtl/cdb_arbiter.sv
// CDB arbiter: per-port one-entry buffers drained round-robin
// onto a registered common data bus.
package cdb_pkg;

  typedef struct packed {
    logic        execute_valid;
    logic [5:0]  phys_rd;
    logic [31:0] phys_rd_val;
    logic [4:0]  rob_index;
  } data_bus_package_t;

endpackage

module cdb_arbiter
  import cdb_pkg::*;
#(
  parameter int NUM_REQ = 4,
  localparam int IW = $clog2(NUM_REQ)
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [NUM_REQ-1:0]     req_valid,
  input  data_bus_package_t      req_pkt [NUM_REQ],
  output logic [NUM_REQ-1:0]     req_ready,
  input  logic                   flush,
  output logic                   cdb_valid,
  output data_bus_package_t      cdb_pkt,
  output logic [IW-1:0]          cdb_grant_idx
);

  logic [NUM_REQ-1:0] buf_valid_q, buf_valid_d;
  data_bus_package_t  buf_pkt_q [NUM_REQ];
  data_bus_package_t  buf_pkt_d [NUM_REQ];
  logic [IW-1:0]      ptr_q, ptr_d;
  logic               cdb_valid_q, cdb_valid_d;
  data_bus_package_t  cdb_pkt_q, cdb_pkt_d;
  logic [IW-1:0]      gidx_q, gidx_d;

  logic [NUM_REQ-1:0] grant;
  logic [IW-1:0]      gnt_idx;
  logic               gnt_any;
  logic [IW-1:0]      ptr_nxt;

  // Round-robin scan of full buffers starting at ptr
  always_comb begin
    int            scan;
    logic [IW-1:0] si;
    grant   = '0;
    gnt_idx = ptr_q;
    gnt_any = 1'b0;
    scan    = 0;
    si      = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      scan = int'(ptr_q) + k;
      if (scan >= NUM_REQ) scan = scan - NUM_REQ;
      si = IW'(scan);
      if (!gnt_any && buf_valid_q[si] && !flush) begin
        gnt_any   = 1'b1;
        gnt_idx   = si;
        grant[si] = 1'b1;
      end
    end
    if (int'(gnt_idx) == NUM_REQ - 1) ptr_nxt = '0;
    else                              ptr_nxt = gnt_idx + IW'(1);
  end

  // Ready only when the buffer is empty or draining this cycle
  assign req_ready = {NUM_REQ{rst}}
                   & {NUM_REQ{~flush}}
                   & (~buf_valid_q | grant);

  // Next-state: grant drains, accept refills, flush squashes
  always_comb begin
    buf_valid_d = buf_valid_q;
    buf_pkt_d   = buf_pkt_q;
    ptr_d       = ptr_q;
    cdb_valid_d = 1'b0;
    cdb_pkt_d   = '0;
    gidx_d      = gidx_q;
    if (flush) begin
      buf_valid_d = '0;
    end else begin
      if (gnt_any) begin
        buf_valid_d[gnt_idx]    = 1'b0;
        cdb_valid_d             = 1'b1;
        cdb_pkt_d               = buf_pkt_q[gnt_idx];
        cdb_pkt_d.execute_valid = 1'b1;
        gidx_d                  = gnt_idx;
        ptr_d                   = ptr_nxt;
      end
      for (int i = 0; i < NUM_REQ; i++) begin
        if (req_valid[i] && req_ready[i]) begin
          buf_valid_d[i] = 1'b1;
          buf_pkt_d[i]   = req_pkt[i];
        end
      end
    end
  end

  // State registers
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      buf_valid_q <= '0;
      for (int i = 0; i < NUM_REQ; i++) buf_pkt_q[i] <= '0;
      ptr_q       <= '0;
      cdb_valid_q <= 1'b0;
      cdb_pkt_q   <= '0;
      gidx_q      <= '0;
    end else begin
      buf_valid_q <= buf_valid_d;
      for (int i = 0; i < NUM_REQ; i++) buf_pkt_q[i] <= buf_pkt_d[i];
      ptr_q       <= ptr_d;
      cdb_valid_q <= cdb_valid_d;
      cdb_pkt_q   <= cdb_pkt_d;
      gidx_q      <= gidx_d;
    end
  end

  assign cdb_valid     = cdb_valid_q;
  assign cdb_pkt       = cdb_pkt_q;
  assign cdb_grant_idx = gidx_q;

endmodule

// File: tb/tb_cdb_arbiter.sv
// Directed bench for cdb_arbiter: reset, single, contention,
// streaming, flush and async reset.
module tb_cdb_arbiter;
  import cdb_pkg::*;

  logic              clk;
  logic              rst;
  logic [3:0]        req_valid;
  data_bus_package_t req_pkt [4];
  logic [3:0]        req_ready;
  logic              flush;
  logic              cdb_valid;
  data_bus_package_t cdb_pkt;
  logic [1:0]        cdb_grant_idx;

  int total;
  int passes;
  bit done;

  cdb_arbiter #(.NUM_REQ(4)) dut (
    .clk           (clk),
    .rst           (rst),
    .req_valid     (req_valid),
    .req_pkt       (req_pkt),
    .req_ready     (req_ready),
    .flush         (flush),
    .cdb_valid     (cdb_valid),
    .cdb_pkt       (cdb_pkt),
    .cdb_grant_idx (cdb_grant_idx)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(
    input string       tag,
    input logic [63:0] o,
    input logic [63:0] e
  );
    total++;
    if (o === e) passes++;
    else $error("FAIL %s: got %0h want %0h", tag, o, e);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic data_bus_package_t mk(
    input logic [5:0]  rd,
    input logic [31:0] v,
    input logic [4:0]  rob
  );
    data_bus_package_t p;
    p.execute_valid = 1'b0;
    p.phys_rd       = rd;
    p.phys_rd_val   = v;
    p.rob_index     = rob;
    return p;
  endfunction

  initial begin
    #100000;
    if (!done) begin
      $error("FAIL timeout: bench did not finish");
      $finish;
    end
  end

  initial begin
    logic [1:0] g;
    done   = 1'b0;
    total  = 0;
    passes = 0;
    rst    = 1'b0;
    flush  = 1'b0;
    req_valid = 4'hF;
    for (int i = 0; i < 4; i++)
      req_pkt[i] = mk(6'd1, 32'h11, 5'd1);

    #1;
    chk("rst_ready", req_ready, 4'h0);
    chk("rst_valid", cdb_valid, 1'b0);
    chk("rst_pkt", cdb_pkt, '0);
    chk("rst_idx", cdb_grant_idx, 2'd0);
    tick();
    tick();
    chk("rst_ready2", req_ready, 4'h0);
    chk("rst_valid2", cdb_valid, 1'b0);
    req_valid = 4'h0;
    rst = 1'b1;
    #1;
    chk("rel_ready", req_ready, 4'hF);

    req_valid  = 4'b0100;
    req_pkt[2] = mk(6'd5, 32'hDEADBEEF, 5'd3);
    tick();
    req_valid = 4'h0;
    chk("s_val0", cdb_valid, 1'b0);
    tick();
    chk("s_val1", cdb_valid, 1'b1);
    chk("s_idx", cdb_grant_idx, 2'd2);
    chk("s_data", cdb_pkt.phys_rd_val, 32'hDEADBEEF);
    chk("s_rd", cdb_pkt.phys_rd, 6'd5);
    chk("s_rob", cdb_pkt.rob_index, 5'd3);
    chk("s_ev", cdb_pkt.execute_valid, 1'b1);
    chk("s_ptr", dut.ptr_q, 2'd3);
    tick();
    chk("s_val2", cdb_valid, 1'b0);
    chk("s_pkt2", cdb_pkt, '0);

    #2 rst = 1'b0;
    #1 rst = 1'b1;
    chk("r_ptr", dut.ptr_q, 2'd0);

    for (int i = 0; i < 4; i++)
      req_pkt[i] = mk(6'(i), 32'hA0 + i, 5'(i));
    req_valid = 4'hF;
    tick();
    chk("c_val0", cdb_valid, 1'b0);
    g = 2'd0;
    for (int k = 0; k < 6; k++) begin
      tick();
      chk("c_val", cdb_valid, 1'b1);
      chk("c_idx", cdb_grant_idx, g);
      chk("c_data", cdb_pkt.phys_rd_val,
          32'hA0 + 32'(g));
      chk("c_ready", req_ready,
          4'(4'b0001 << (g + 2'd1)));
      g = g + 2'd1;
    end
    req_valid = 4'h0;
    for (int k = 0; k < 4; k++) begin
      tick();
      chk("d_idx", cdb_grant_idx, g);
      chk("d_val", cdb_valid, 1'b1);
      g = g + 2'd1;
    end
    tick();
    chk("d_idle", cdb_valid, 1'b0);
    chk("d_ptr", dut.ptr_q, 2'd2);

    for (int k = 1; k <= 8; k++) begin
      req_valid  = 4'b0010;
      req_pkt[1] = mk(6'd9, 32'(k), 5'd7);
      chk("st_ready", req_ready[1], 1'b1);
      tick();
      if (k == 1) begin
        chk("st_first", cdb_valid, 1'b0);
      end else begin
        chk("st_val", cdb_valid, 1'b1);
        chk("st_data", cdb_pkt.phys_rd_val,
            32'(k - 1));
        chk("st_idx", cdb_grant_idx, 2'd1);
      end
    end
    req_valid = 4'h0;
    tick();
    chk("st_last", cdb_pkt.phys_rd_val, 32'd8);
    tick();
    chk("st_end", cdb_valid, 1'b0);
    chk("st_ptr", dut.ptr_q, 2'd2);

    req_valid  = 4'b1001;
    req_pkt[0] = mk(6'd2, 32'h111, 5'd4);
    req_pkt[3] = mk(6'd3, 32'h333, 5'd6);
    tick();
    req_valid = 4'h0;
    flush = 1'b1;
    #1;
    chk("f_ready_in", req_ready, 4'h0);
    tick();
    flush = 1'b0;
    #1;
    chk("f_val", cdb_valid, 1'b0);
    chk("f_ready", req_ready, 4'hF);
    chk("f_ptr", dut.ptr_q, 2'd2);
    tick();
    chk("f_val2", cdb_valid, 1'b0);
    tick();
    chk("f_val3", cdb_valid, 1'b0);

    req_valid  = 4'b0101;
    req_pkt[0] = mk(6'd4, 32'h55, 5'd8);
    req_pkt[2] = mk(6'd6, 32'h77, 5'd9);
    tick();
    req_valid = 4'h0;
    tick();
    chk("a_val", cdb_valid, 1'b1);
    chk("a_data", cdb_pkt.phys_rd_val, 32'h77);
    #2 rst = 1'b0;
    #1;
    chk("a_drop", cdb_valid, 1'b0);
    chk("a_pkt", cdb_pkt, '0);
    chk("a_ready", req_ready, 4'h0);
    #1 rst = 1'b1;
    tick();
    chk("a_lost1", cdb_valid, 1'b0);
    tick();
    chk("a_lost2", cdb_valid, 1'b0);
    chk("a_ptr", dut.ptr_q, 2'd0);

    done = 1'b1;
    $display("%0d/%0d checks passed", passes, total);
    $finish;
  end

endmodule
